// File: rtl/pix_wr_pkg.sv
// rtl/pix_wr_pkg.sv - shared state encoding, pad constant and width helper for the pixel write stage
package pix_wr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } wr_state_t;

  // Upper byte of every 32-bit memory word; pixels are 24-bit RGB.
  localparam logic [7:0] PIX_PAD = 8'h00;

  // Occupancy counter width: one more bit than a pointer so "full" is representable.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pix_wr_if.sv
// rtl/pix_wr_if.sv - pixel-in / word-write-out bus bundle for the write stage
interface pix_wr_if #(
  parameter int ADDR_W = 24
);
  logic [23:0]       pix_data;
  logic              pix_valid;
  logic              pix_sof;
  logic              wr_rdy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  // Source side: pixel producer plus memory-ready feedback.
  modport master (
    output pix_data, pix_valid, pix_sof, wr_rdy,
    input  wr_en, wr_addr, wr_data
  );

  // Write-stage side.
  modport slave (
    input  pix_data, pix_valid, pix_sof, wr_rdy,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/pix_fifo.sv
// rtl/pix_fifo.sv - register-based single-clock FIFO, head visible combinationally
module pix_fifo
  import pix_wr_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16
) (
  input  logic                      CLOCK_125_p,
  input  logic                      reset,
  input  logic                      push,
  input  logic [WIDTH-1:0]          din,
  input  logic                      pop,
  output logic [WIDTH-1:0]          dout,
  output logic [level_w(DEPTH)-1:0] level,
  output logic                      full,
  output logic                      empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LVL_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  assign level   = count;

  // Storage array: data only, no reset needed since count gates every read.
  always_ff @(posedge CLOCK_125_p) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge CLOCK_125_p or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pix_wr_stage.sv
// rtl/pix_wr_stage.sv - frame pixel capture, address assignment and buffered word writes
module pix_wr_stage
  import pix_wr_pkg::*;
#(
  parameter int                FRAME_PIX  = 307200,
  parameter int                ADDR_W     = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                FIFO_DEPTH = 16
) (
  input  logic                           CLOCK_125_p,
  input  logic                           reset,
  pix_wr_if.slave                        bus,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           overflow,
  output logic                           sync_err,
  output logic [level_w(FIFO_DEPTH)-1:0] fifo_level
);
  localparam int CNT_W = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam int ENT_W = ADDR_W + 24;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIX - 1);

  wr_state_t        state_q, state_d;
  logic [CNT_W-1:0] pix_idx_q, pix_idx_d;
  logic [CNT_W-1:0] push_idx;
  logic             push_req;
  logic             push_ok;
  logic             drop;
  logic             sync_hit;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ENT_W-1:0] fifo_din;
  logic [ENT_W-1:0] fifo_dout;

  assign busy     = (state_q != ST_IDLE);
  assign pop      = !fifo_empty && bus.wr_rdy;
  assign push_ok  = push_req && (!fifo_full || pop);
  // Dropped pixels still consume an index so later pixels keep their addresses.
  assign drop     = push_req && !push_ok;
  assign fifo_din = {BASE_ADDR + ADDR_W'(push_idx), bus.pix_data};

  pix_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLOCK_125_p (CLOCK_125_p),
    .reset       (reset),
    .push        (push_ok),
    .din         (fifo_din),
    .pop         (pop),
    .dout        (fifo_dout),
    .level       (fifo_level),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  // Frame FSM: decide whether this pixel is captured, at which index, and the next phase.
  always_comb begin
    state_d    = state_q;
    pix_idx_d  = pix_idx_q;
    push_idx   = pix_idx_q;
    push_req   = 1'b0;
    sync_hit   = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.pix_valid && bus.pix_sof) begin
          push_req = 1'b1;
          push_idx = '0;
        end
      end
      ST_CAPTURE: begin
        if (bus.pix_valid) begin
          push_req = 1'b1;
          if (bus.pix_sof) begin
            sync_hit = 1'b1;
            push_idx = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && !bus.wr_en) begin
          frame_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (push_req) begin
      if (push_idx == LAST_IDX) begin
        state_d   = ST_DRAIN;
        pix_idx_d = '0;
      end else begin
        state_d   = ST_CAPTURE;
        pix_idx_d = push_idx + 1'b1;
      end
    end
  end

  // State and pixel counter registers.
  always_ff @(posedge CLOCK_125_p or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pix_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      pix_idx_q <= pix_idx_d;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge CLOCK_125_p or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      if (drop)     overflow <= 1'b1;
      if (sync_hit) sync_err <= 1'b1;
    end
  end

  // Write port: register the FIFO head on a pop; address/data hold between strobes.
  always_ff @(posedge CLOCK_125_p or negedge reset) begin
    if (!reset) begin
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      bus.wr_en <= pop;
      if (pop) begin
        bus.wr_addr <= fifo_dout[ENT_W-1:24];
        bus.wr_data <= {PIX_PAD, fifo_dout[23:0]};
      end
    end
  end

endmodule

// File: doc/pix_wr_stage.md
Name: pix_wr_stage

Overview:
Upstream write-side stage for one frame-buffer port. It accepts a 24-bit pixel stream with start-of-frame and assigns each pixel a linear word address. Pixels are buffered in a small FIFO and drained as single-word writes toward the memory interface under wr_rdy flow control. It reports frame completion and sticky error flags for probing.

Parameters:
FRAME_PIX, 307200, pixels per frame (640x480); bench uses 8
BASE_ADDR, 24'h000000, word address of pixel 0
FIFO_DEPTH, 16, FIFO entries; power of 2, at least 4
ADDR_W, 24, write address width

Ports:
CLOCK_125_p  in   1       clock
reset        in   1       asynchronous, active-low reset
pix_data     in   24      RGB pixel
pix_valid    in   1       pixel present this cycle
pix_sof      in   1       qualifies pix_valid: this pixel is index 0 of a frame
wr_rdy       in   1       memory side can accept a write next cycle
wr_en        out  1       one-cycle write strobe, one per word
wr_addr      out  ADDR_W  write word address
wr_data      out  32      {8'h00, pixel}
busy         out  1       state != IDLE
frame_done   out  1       one-cycle pulse when a frame is fully written
overflow     out  1       sticky: a pixel was dropped
sync_err     out  1       sticky: sof arrived mid-frame
fifo_level   out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync deassert): all outputs 0, state IDLE, FIFO empty, pixel counter 0, sticky flags cleared. Reset mid-frame discards FIFO contents; no further wr_en is issued.
- Pixel counter pix_idx runs 0..FRAME_PIX-1. Each push stores {BASE_ADDR+pix_idx, pix_data} in the FIFO (entry width ADDR_W+24). The address travels with the data.
- States:
  - IDLE:
    - pix_valid && !pix_sof: ignored.
    - pix_valid && pix_sof: push with pix_idx=0, set pix_idx=1, go to CAPTURE.
  - CAPTURE:
    - Each pix_valid pushes at pix_idx, then pix_idx increments.
    - The push at pix_idx=FRAME_PIX-1 goes to DRAIN.
    - pix_valid && pix_sof: set sync_err, treat the pixel as index 0 (pix_idx=1 next), stay in CAPTURE. Earlier entries still drain to their stored addresses.
  - DRAIN:
    - pix_valid is ignored. A pix_sof arriving here is not captured (it is dropped and no flag is set).
    - When FIFO is empty and wr_en is low, pulse frame_done for one cycle and go to IDLE.
- Push acceptance:
  - A push is accepted if level<FIFO_DEPTH, or if level==FIFO_DEPTH and a pop occurs in the same cycle.
  - Otherwise the pixel is dropped, overflow is set, and pix_idx still advances so later pixels keep correct addresses.
- Pop: when level!=0 && wr_rdy, register the head into wr_addr/wr_data and assert wr_en for the next cycle. Back-to-back pops occur while wr_rdy stays high.
- When wr_en=0, wr_addr and wr_data hold their last values.
- Latency: pixel valid in cycle 0 with FIFO empty and wr_rdy high gives wr_en high in cycle 2.
- Push and pop in the same cycle leave level unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. level is an explicit counter (ptr+1 bit).
- Sticky flags clear only on reset.

Decomposition:
- Package pix_wr_pkg: state encoding (IDLE, CAPTURE, DRAIN), the zero-pad constant 8'h00, and a level-width function.
- Sub-module pix_fifo: synchronous single-clock FIFO with push/pop/level/full/empty. Register-based, parameterised by width and depth, no output register.
- The top-level FSM, pixel counter and output register live in pix_wr_stage.

Test Plan:
1. FRAME_PIX=8, wr_rdy=1: sof + 8 pixels 0x000001..0x000008 on consecutive cycles.
   - Required: wr_en on cycles 2..9, addr 0..7, data 0x00000001..0x00000008.
   - Required: frame_done pulses once in cycle 10; busy then 0.
2. Backpressure: same stimulus with wr_rdy low on cycles 3..6.
   - Required: no wr_en during the stall; all 8 words later delivered in order with correct addresses.
   - Required: max fifo_level equals the observed peak, never more than FIFO_DEPTH.
3. Overflow: FIFO_DEPTH=4, FRAME_PIX=8, wr_rdy=0 throughout capture, then 1.
   - Required: pixels 4..7 are dropped and overflow=1.
   - Required: exactly 4 writes, to addresses 0..3; frame_done pulses after the fourth write.
4. Mid-frame sof: sof at pixel 0 and again at pixel 3.
   - Required: sync_err=1; writes go to addrs 0,1,2, then 0..7 for the restarted frame; one frame_done.
5. Reset mid-frame: assert reset during CAPTURE with 3 entries queued.
   - Required: all outputs 0 immediately; no wr_en after release.
   - Required: a new sof frame completes normally from addr 0.
